// File: rtl/axi_mst_initiator.sv
// rtl/axi_mst_initiator.sv - AXI master initiator: one command at a time, outstanding-limited reads/writes
// Optional macro MST_RLAST_CHK_EN enables read rlast/rid checking with a stored-ID FIFO.
module axi_mst_initiator #(
    parameter int AXI_ADDR_W      = 32,
    parameter int AXI_ID_W        = 4,
    parameter int AXI_DATA_W      = 32,
    parameter int MST_OSTDREQ_NUM = 4
) (
    input  logic                           aclk,
    input  logic                           srst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [AXI_ADDR_W-1:0]          cmd_addr,
    input  logic [3:0]                     cmd_len,
    input  logic [AXI_ID_W-1:0]            cmd_id,
    output logic                           out_awvalid,
    input  logic                           in_awready,
    output logic [AXI_ADDR_W-1:0]          out_awaddr,
    output logic [3:0]                     out_awlen,
    output logic [2:0]                     out_awsize,
    output logic [1:0]                     out_awburst,
    output logic [AXI_ID_W-1:0]            out_awid,
    output logic                           out_wvalid,
    input  logic                           in_wready,
    output logic [AXI_ID_W-1:0]            out_wid,
    output logic [AXI_DATA_W-1:0]          out_wdata,
    output logic [AXI_DATA_W/8-1:0]        out_wstrb,
    output logic                           out_wlast,
    input  logic                           in_bvalid,
    output logic                           out_bready,
    input  logic [AXI_ID_W-1:0]            in_bid,
    input  logic [1:0]                     in_bresp,
    output logic                           out_arvalid,
    input  logic                           in_arready,
    output logic [AXI_ADDR_W-1:0]          out_araddr,
    output logic [3:0]                     out_arlen,
    output logic [2:0]                     out_arsize,
    output logic [1:0]                     out_arburst,
    output logic [AXI_ID_W-1:0]            out_arid,
    input  logic                           in_rvalid,
    output logic                           out_rready,
    input  logic [AXI_ID_W-1:0]            in_rid,
    input  logic [AXI_DATA_W-1:0]          in_rdata,
    input  logic                           in_rlast,
    output logic [$clog2(MST_OSTDREQ_NUM):0] rd_ostd_cnt,
    output logic [$clog2(MST_OSTDREQ_NUM):0] wr_ostd_cnt,
    output logic                           err_bresp,
    output logic                           err_rlast,
    output logic                           idle
);

    localparam int CW = $clog2(MST_OSTDREQ_NUM) + 1;
    localparam int PW = (MST_OSTDREQ_NUM > 1) ? $clog2(MST_OSTDREQ_NUM) : 1;
    localparam int SW = (AXI_ADDR_W > AXI_DATA_W) ? AXI_ADDR_W : AXI_DATA_W;
    localparam logic [2:0]    AXSIZE   = 3'($clog2(AXI_DATA_W / 8));
    localparam logic [CW-1:0] OSTD_MAX = CW'(MST_OSTDREQ_NUM);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_AW, S_W} state_t;

    state_t                state, state_nxt;
    logic [AXI_ADDR_W-1:0] lat_addr;
    logic [3:0]            lat_len;
    logic [AXI_ID_W-1:0]   lat_id;
    logic [3:0]            wbeat;
    logic [3:0]            rbeat;
    logic [CW-1:0]         rd_cnt, wr_cnt;
    logic [PW-1:0]         wptr, rptr;
    logic [3:0]            len_mem [MST_OSTDREQ_NUM];
    logic [SW-1:0]         wsum;
    logic                  cmd_fire, ar_fire, aw_fire, w_fire, w_done, b_fire, r_fire, r_done;

    assign cmd_ready = !srst && (state == S_IDLE) &&
                       (cmd_write ? (wr_cnt < OSTD_MAX) : (rd_cnt < OSTD_MAX));
    assign out_bready = !srst && (wr_cnt != '0);
    assign out_rready = !srst && (rd_cnt != '0);

    assign cmd_fire = cmd_valid && cmd_ready;
    assign ar_fire  = out_arvalid && in_arready;
    assign aw_fire  = out_awvalid && in_awready;
    assign w_fire   = out_wvalid && in_wready;
    assign w_done   = w_fire && out_wlast;
    assign b_fire   = in_bvalid && out_bready;
    assign r_fire   = in_rvalid && out_rready;
    assign r_done   = r_fire && in_rlast;

    assign wsum        = SW'(lat_addr) + SW'(wbeat);
    assign out_wdata   = wsum[AXI_DATA_W-1:0];
    assign out_awaddr  = lat_addr;
    assign out_araddr  = lat_addr;
    assign out_awlen   = lat_len;
    assign out_arlen   = lat_len;
    assign out_awid    = lat_id;
    assign out_arid    = lat_id;
    assign out_wid     = lat_id;
    assign rd_ostd_cnt = rd_cnt;
    assign wr_ostd_cnt = wr_cnt;
    assign idle        = (state == S_IDLE) && (rd_cnt == '0) && (wr_cnt == '0);

    always_comb begin
        state_nxt   = state;
        out_arvalid = 1'b0;
        out_awvalid = 1'b0;
        out_wvalid  = 1'b0;
        out_wlast   = 1'b0;
        out_wstrb   = '0;
        out_arsize  = 3'd0;
        out_arburst = 2'b00;
        out_awsize  = 3'd0;
        out_awburst = 2'b00;
        case (state)
            S_IDLE: if (cmd_fire) state_nxt = cmd_write ? S_AW : S_AR;
            S_AR: begin
                out_arvalid = 1'b1;
                out_arsize  = AXSIZE;
                out_arburst = 2'b01;
                if (in_arready) state_nxt = S_IDLE;
            end
            S_AW: begin
                out_awvalid = 1'b1;
                out_awsize  = AXSIZE;
                out_awburst = 2'b01;
                if (in_awready) state_nxt = S_W;
            end
            S_W: begin
                out_wvalid = 1'b1;
                out_wstrb  = '1;
                out_wlast  = (wbeat == lat_len);
                if (in_wready && out_wlast) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state     <= S_IDLE;
            lat_addr  <= '0;
            lat_len   <= '0;
            lat_id    <= '0;
            wbeat     <= '0;
            rbeat     <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            wptr      <= '0;
            rptr      <= '0;
            err_bresp <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_fire) begin
                lat_addr <= cmd_addr;
                lat_len  <= cmd_len;
                lat_id   <= cmd_id;
            end
            if (aw_fire)      wbeat <= '0;
            else if (w_fire)  wbeat <= wbeat + 4'd1;
            if (r_done)       rbeat <= '0;
            else if (r_fire)  rbeat <= rbeat + 4'd1;
            // Simultaneous issue and retire cancel out, leaving the count unchanged.
            case ({ar_fire, r_done})
                2'b10:   rd_cnt <= rd_cnt + CW'(1);
                2'b01:   rd_cnt <= rd_cnt - CW'(1);
                default: rd_cnt <= rd_cnt;
            endcase
            case ({w_done, b_fire})
                2'b10:   wr_cnt <= wr_cnt + CW'(1);
                2'b01:   wr_cnt <= wr_cnt - CW'(1);
                default: wr_cnt <= wr_cnt;
            endcase
            if (ar_fire) wptr <= wptr + PW'(1);
            if (r_done)  rptr <= rptr + PW'(1);
            if (b_fire && (in_bresp != 2'b00)) err_bresp <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (ar_fire) len_mem[wptr] <= lat_len;
    end

`ifdef MST_RLAST_CHK_EN
    logic [AXI_ID_W-1:0] id_mem [MST_OSTDREQ_NUM];
    logic                rd_err;

    assign rd_err = (in_rlast != (rbeat == len_mem[rptr])) || (in_rid != id_mem[rptr]);

    always_ff @(posedge aclk) begin
        if (ar_fire) id_mem[wptr] <= lat_id;
    end

    always_ff @(posedge aclk) begin
        if (srst)                  err_rlast <= 1'b0;
        else if (r_fire && rd_err) err_rlast <= 1'b1;
    end

    logic unused_inputs;
    assign unused_inputs = ^{in_bid, in_rdata};
`else
    assign err_rlast = 1'b0;

    // Length FIFO and beat counter are only consulted by the optional read check.
    logic unused_inputs;
    assign unused_inputs = ^{in_bid, in_rdata, in_rid, rbeat, len_mem[rptr]};
`endif

endmodule

// File: tb/tb_axi_mst_initiator.sv
// tb/tb_axi_mst_initiator.sv - self-checking bench for axi_mst_initiator: transaction model plus directed and random stimulus
module tb_axi_mst_initiator;

    logic        aclk = 1'b0;
    logic        srst, cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len, cmd_id;
    logic        out_awvalid, in_awready;
    logic [31:0] out_awaddr;
    logic [3:0]  out_awlen, out_awid;
    logic [2:0]  out_awsize;
    logic [1:0]  out_awburst;
    logic        out_wvalid, in_wready, out_wlast;
    logic [3:0]  out_wid, out_wstrb;
    logic [31:0] out_wdata;
    logic        in_bvalid, out_bready;
    logic [3:0]  in_bid;
    logic [1:0]  in_bresp;
    logic        out_arvalid, in_arready;
    logic [31:0] out_araddr;
    logic [3:0]  out_arlen, out_arid;
    logic [2:0]  out_arsize;
    logic [1:0]  out_arburst;
    logic        in_rvalid, out_rready, in_rlast;
    logic [3:0]  in_rid;
    logic [31:0] in_rdata;
    logic [2:0]  rd_ostd_cnt, wr_ostd_cnt;
    logic        err_bresp, err_rlast, idle;

    always #5 aclk = ~aclk;

    axi_mst_initiator dut (
        .aclk(aclk), .srst(srst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .out_awvalid(out_awvalid), .in_awready(in_awready), .out_awaddr(out_awaddr),
        .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst), .out_awid(out_awid),
        .out_wvalid(out_wvalid), .in_wready(in_wready), .out_wid(out_wid), .out_wdata(out_wdata),
        .out_wstrb(out_wstrb), .out_wlast(out_wlast),
        .in_bvalid(in_bvalid), .out_bready(out_bready), .in_bid(in_bid), .in_bresp(in_bresp),
        .out_arvalid(out_arvalid), .in_arready(in_arready), .out_araddr(out_araddr),
        .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst), .out_arid(out_arid),
        .in_rvalid(in_rvalid), .out_rready(out_rready), .in_rid(in_rid), .in_rdata(in_rdata),
        .in_rlast(in_rlast),
        .rd_ostd_cnt(rd_ostd_cnt), .wr_ostd_cnt(wr_ostd_cnt),
        .err_bresp(err_bresp), .err_rlast(err_rlast), .idle(idle)
    );

    int compared = 0;
    int mismatched = 0;

    // Transaction-level model: at most one command in flight, plus outstanding counts and an in-order read queue.
    bit          m_active, m_write, m_aw_done, m_eb, m_er;
    logic [31:0] m_addr;
    logic [3:0]  m_len, m_id;
    int          m_beats, m_rd, m_wr, m_rbeat;
    logic [3:0]  rq_len[$];
    logic [3:0]  rq_id[$];
    logic [32:0] w_seen[$];

`ifdef MST_RLAST_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_write = 0; m_aw_done = 0; m_eb = 0; m_er = 0;
        m_addr = '0; m_len = '0; m_id = '0;
        m_beats = 0; m_rd = 0; m_wr = 0; m_rbeat = 0;
        rq_len.delete(); rq_id.delete();
    endtask

    task automatic compare_all();
        bit e_cr, e_ar, e_aw, e_w;
        e_cr = !srst && !m_active && (cmd_write ? (m_wr < 4) : (m_rd < 4));
        e_ar = m_active && !m_write;
        e_aw = m_active && m_write && !m_aw_done;
        e_w  = m_active && m_write && m_aw_done;
        chk("cmd_ready", 64'(cmd_ready), 64'(e_cr));
        chk("arvalid", 64'(out_arvalid), 64'(e_ar));
        chk("awvalid", 64'(out_awvalid), 64'(e_aw));
        chk("wvalid", 64'(out_wvalid), 64'(e_w));
        chk("bready", 64'(out_bready), 64'(!srst && m_wr != 0));
        chk("rready", 64'(out_rready), 64'(!srst && m_rd != 0));
        chk("rd_ostd_cnt", 64'(rd_ostd_cnt), 64'(m_rd));
        chk("wr_ostd_cnt", 64'(wr_ostd_cnt), 64'(m_wr));
        chk("err_bresp", 64'(err_bresp), 64'(m_eb));
        chk("err_rlast", 64'(err_rlast), 64'(m_er));
        chk("idle", 64'(idle), 64'(!m_active && m_rd == 0 && m_wr == 0));
        if (e_ar) begin
            chk("araddr", 64'(out_araddr), 64'(m_addr));
            chk("arlen", 64'(out_arlen), 64'(m_len));
            chk("arid", 64'(out_arid), 64'(m_id));
            chk("arsize", 64'(out_arsize), 64'd2);
            chk("arburst", 64'(out_arburst), 64'd1);
        end
        if (e_aw) begin
            chk("awaddr", 64'(out_awaddr), 64'(m_addr));
            chk("awlen", 64'(out_awlen), 64'(m_len));
            chk("awid", 64'(out_awid), 64'(m_id));
            chk("awsize", 64'(out_awsize), 64'd2);
            chk("awburst", 64'(out_awburst), 64'd1);
        end
        if (e_w) begin
            chk("wdata", 64'(out_wdata), 64'(m_addr + 32'(m_beats)));
            chk("wstrb", 64'(out_wstrb), 64'hf);
            chk("wid", 64'(out_wid), 64'(m_id));
            chk("wlast", 64'(out_wlast), 64'(m_beats == int'(m_len)));
        end
    endtask

    task automatic model_step();
        bit cr, ar_h, w_last_h, b_h, r_h, r_last_h;
        if (srst) begin
            model_reset();
            return;
        end
        cr       = !m_active && (cmd_write ? (m_wr < 4) : (m_rd < 4));
        ar_h     = m_active && !m_write && in_arready;
        w_last_h = m_active && m_write && m_aw_done && in_wready && (m_beats == int'(m_len));
        b_h      = in_bvalid && (m_wr != 0);
        r_h      = in_rvalid && (m_rd != 0);
        r_last_h = r_h && in_rlast;
        if (r_h) begin
            if (CHK_EN && ((in_rlast != (m_rbeat == int'(rq_len[0]))) || (in_rid != rq_id[0]))) m_er = 1;
            if (in_rlast) begin
                m_rbeat = 0;
                void'(rq_len.pop_front());
                void'(rq_id.pop_front());
            end else begin
                m_rbeat = (m_rbeat + 1) % 16;
            end
        end
        if (b_h && in_bresp != 2'b00) m_eb = 1;
        if (ar_h) begin
            rq_len.push_back(m_len);
            rq_id.push_back(m_id);
            m_active = 0;
        end else if (m_active && m_write && !m_aw_done && in_awready) begin
            m_aw_done = 1;
            m_beats   = 0;
        end else if (m_active && m_write && m_aw_done && in_wready) begin
            if (w_last_h) m_active = 0;
            else          m_beats++;
        end
        m_rd = m_rd + int'(ar_h) - int'(r_last_h);
        m_wr = m_wr + int'(w_last_h) - int'(b_h);
        if (cmd_valid && cr) begin
            m_active  = 1;
            m_write   = cmd_write;
            m_aw_done = 0;
            m_beats   = 0;
            m_addr    = cmd_addr;
            m_len     = cmd_len;
            m_id      = cmd_id;
        end
    endtask

    // Called just after a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle();
        #1;
        compare_all();
        if (out_wvalid && in_wready) w_seen.push_back({out_wlast, out_wdata});
        model_step();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic quiet();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        in_awready = 0; in_wready = 0; in_arready = 0;
        in_bvalid = 0; in_bid = '0; in_bresp = '0;
        in_rvalid = 0; in_rid = '0; in_rdata = '0; in_rlast = 0;
    endtask

    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
        cycle();
        cmd_valid = 0;
    endtask

    task automatic rbeat(input logic [3:0] id, input bit last);
        in_rvalid = 1; in_rid = id; in_rlast = last; in_rdata = $urandom;
        cycle();
        in_rvalid = 0; in_rlast = 0;
    endtask

    initial begin
        quiet();
        model_reset();
        srst = 1;
        @(negedge aclk);
        cycle();
        cycle();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_araddr", 64'(out_araddr), 64'd0);
        chk("rst_wdata", 64'(out_wdata), 64'd0);
        chk("rst_wlast", 64'(out_wlast), 64'd0);
        srst = 0;

        // Read: addr 0x100, len 3, id 2
        do_cmd(0, 32'h100, 4'd3, 4'd2);
        chk("rd_arvalid_lit", 64'(out_arvalid), 64'd1);
        chk("rd_araddr_lit", 64'(out_araddr), 64'h100);
        chk("rd_arlen_lit", 64'(out_arlen), 64'd3);
        in_arready = 1; cycle(); in_arready = 0;
        chk("rd_cnt_one_lit", 64'(rd_ostd_cnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            rbeat(4'd2, i == 3);
            if (i == 2) chk("rd_cnt_mid_lit", 64'(rd_ostd_cnt), 64'd1);
        end
        chk("rd_cnt_zero_lit", 64'(rd_ostd_cnt), 64'd0);
        chk("rd_err_rlast_lit", 64'(err_rlast), 64'd0);

        // Write: addr 0x40, len 1
        w_seen.delete();
        do_cmd(1, 32'h40, 4'd1, 4'd5);
        in_awready = 1; in_wready = 1;
        cycle(); cycle(); cycle();
        in_awready = 0; in_wready = 0;
        chk("wr_beats_lit", 64'(w_seen.size()), 64'd2);
        if (w_seen.size() >= 2) begin
            chk("wr_beat0_lit", 64'(w_seen[0]), {31'd0, 1'b0, 32'h40});
            chk("wr_beat1_lit", 64'(w_seen[1]), {31'd0, 1'b1, 32'h41});
        end
        chk("wr_cnt_one_lit", 64'(wr_ostd_cnt), 64'd1);
        in_bvalid = 1; cycle(); in_bvalid = 0;
        chk("wr_cnt_zero_lit", 64'(wr_ostd_cnt), 64'd0);
        chk("wr_err_bresp_lit", 64'(err_bresp), 64'd0);

        // Four outstanding reads fill the read side only
        for (int k = 0; k < 4; k++) begin
            do_cmd(0, 32'h200 + 32'(k * 16), 4'd0, 4'(k));
            in_arready = 1; cycle(); in_arready = 0;
        end
        chk("full_rd_cnt_lit", 64'(rd_ostd_cnt), 64'd4);
        cmd_valid = 1; cmd_write = 0;
        #1 chk("full_rd_ready_lit", 64'(cmd_ready), 64'd0);
        cmd_write = 1;
        #1 chk("full_wr_ready_lit", 64'(cmd_ready), 64'd1);
        cmd_valid = 0;
        for (int k = 0; k < 4; k++) rbeat(4'(k), 1'b1);
        chk("full_drained_lit", 64'(rd_ostd_cnt), 64'd0);

        // Write completion coinciding with a B handshake, then B with nothing outstanding
        do_cmd(1, 32'h80, 4'd0, 4'd1);
        in_awready = 1; cycle(); in_awready = 0;
        in_wready = 1; cycle(); in_wready = 0;
        do_cmd(1, 32'h90, 4'd1, 4'd1);
        in_awready = 1; cycle(); in_awready = 0;
        in_wready = 1; cycle();
        in_bvalid = 1; cycle();
        in_wready = 0; in_bvalid = 0;
        chk("same_cyc_wr_lit", 64'(wr_ostd_cnt), 64'd1);
        in_bvalid = 1; cycle(); cycle(); in_bvalid = 0;
        chk("wr_underflow_lit", 64'(wr_ostd_cnt), 64'd0);

        // AR issue coinciding with a final R beat, then R with nothing outstanding
        do_cmd(0, 32'h300, 4'd0, 4'd3);
        in_arready = 1; cycle(); in_arready = 0;
        do_cmd(0, 32'h310, 4'd0, 4'd4);
        in_arready = 1; in_rvalid = 1; in_rid = 4'd3; in_rlast = 1;
        cycle();
        quiet();
        chk("same_cyc_rd_lit", 64'(rd_ostd_cnt), 64'd1);
        rbeat(4'd4, 1'b1);
        rbeat(4'd4, 1'b1);
        chk("rd_underflow_lit", 64'(rd_ostd_cnt), 64'd0);

        // W backpressure on a 4-beat burst
        w_seen.delete();
        do_cmd(1, 32'h500, 4'd3, 4'd6);
        in_awready = 1; cycle(); in_awready = 0;
        for (int i = 0; i < 12; i++) begin
            in_wready = (i % 2 == 0);
            cycle();
        end
        in_wready = 0;
        chk("bp_beats_lit", 64'(w_seen.size()), 64'd4);
        for (int i = 0; i < w_seen.size() && i < 4; i++)
            chk("bp_beat_lit", 64'(w_seen[i]), {31'd0, 1'(i == 3), 32'h500 + 32'(i)});

        // Error response stays sticky
        in_bvalid = 1; in_bresp = 2'b10; cycle(); in_bvalid = 0; in_bresp = 2'b00;
        chk("bresp_err_lit", 64'(err_bresp), 64'd1);
        repeat (5) cycle();
        chk("bresp_sticky_lit", 64'(err_bresp), 64'd1);

        // Early rlast on a 2-beat read
        do_cmd(0, 32'h600, 4'd1, 4'd7);
        in_arready = 1; cycle(); in_arready = 0;
        rbeat(4'd7, 1'b1);
        chk("early_rlast_lit", 64'(err_rlast), 64'(CHK_EN));
        chk("early_rlast_cnt_lit", 64'(rd_ostd_cnt), 64'd0);
        srst = 1; cycle(); srst = 0;
        chk("clr_bresp_lit", 64'(err_bresp), 64'd0);
        chk("clr_rlast_lit", 64'(err_rlast), 64'd0);

        // Randomized traffic with a well-behaved in-order responder and occasional resets
        for (int c = 0; c < 3000; c++) begin
            srst       = ($urandom_range(0, 399) == 0);
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_write  = 1'($urandom_range(0, 1));
            cmd_addr   = $urandom;
            cmd_len    = 4'($urandom_range(0, 7));
            cmd_id     = 4'($urandom_range(0, 15));
            in_awready = ($urandom_range(0, 3) != 0);
            in_wready  = ($urandom_range(0, 3) != 0);
            in_arready = ($urandom_range(0, 3) != 0);
            in_bvalid  = ($urandom_range(0, 2) == 0);
            in_bid     = 4'($urandom_range(0, 15));
            in_bresp   = ($urandom_range(0, 31) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            in_rvalid  = 1'($urandom_range(0, 1));
            in_rdata   = $urandom;
            if (rq_len.size() > 0) begin
                in_rid   = rq_id[0];
                in_rlast = (m_rbeat == int'(rq_len[0]));
            end else begin
                in_rid   = 4'($urandom_range(0, 15));
                in_rlast = 1'($urandom_range(0, 1));
            end
            cycle();
        end
        srst = 0;
        quiet();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axi_mst_initiator.md
AXI_MST_INITIATOR -- requirements
Module: axi_mst_initiator

Interface
REQ-001 SHALL have parameter AXI_ADDR_W, default 32, address width.
REQ-002 SHALL have parameter AXI_ID_W, default 4, ID width.
REQ-003 SHALL have parameter AXI_DATA_W, default 32, data width; legal values are 32 and 64.
REQ-004 SHALL have parameter MST_OSTDREQ_NUM, default 4, max outstanding reads and max outstanding writes (power of 2).
REQ-005 SHALL use one clock and synchronous active-high reset: aclk in 1, rising-edge clock; srst in 1, synchronous active-high reset.
REQ-006 cmd_valid in 1, command present; cmd_ready out 1, command accepted.
REQ-007 cmd_write in 1 (1 = write, 0 = read); cmd_addr in AXI_ADDR_W; cmd_len in 4, beats-1; cmd_id in AXI_ID_W.
REQ-008 AW: out_awvalid out 1; in_awready in 1; out_awaddr out AXI_ADDR_W; out_awlen out 4; out_awsize out 3; out_awburst out 2; out_awid out AXI_ID_W.
REQ-009 W: out_wvalid out 1; in_wready in 1; out_wid out AXI_ID_W; out_wdata out AXI_DATA_W; out_wstrb out AXI_DATA_W/8; out_wlast out 1.
REQ-010 B: in_bvalid in 1; out_bready out 1; in_bid in AXI_ID_W; in_bresp in 2.
REQ-011 AR: out_arvalid out 1; in_arready in 1; out_araddr, out_arlen, out_arsize, out_arburst, out_arid, with widths as on AW.
REQ-012 R: in_rvalid in 1; out_rready out 1; in_rid in AXI_ID_W; in_rdata in AXI_DATA_W; in_rlast in 1.
REQ-013 Status: rd_ostd_cnt out clog2(MST_OSTDREQ_NUM)+1; wr_ostd_cnt out same width; err_bresp out 1; err_rlast out 1; idle out 1.

Function
REQ-014 The FSM SHALL have states IDLE, AR, AW, W.
REQ-015 In IDLE, cmd_ready SHALL be 1 only when the target direction's outstanding count is below MST_OSTDREQ_NUM.
REQ-016 On cmd_valid&&cmd_ready, the command SHALL be latched; the FSM SHALL go to AR if cmd_write=0, else AW.
REQ-017 AR: out_arvalid=1 with the latched fields. On in_arready: go to IDLE, increment rd_ostd_cnt, push cmd_len into the read-length FIFO (depth MST_OSTDREQ_NUM).
REQ-018 AW: out_awvalid=1 with the latched fields; on in_awready go to W, clear the beat counter.
REQ-019 W: out_wvalid=1; out_wdata=cmd_addr+beat index, zero-extended/truncated to AXI_DATA_W; out_wstrb all ones; out_wid=cmd_id.
REQ-020 W: out_wlast=1 when beat index==latched len. Each in_wready advances the beat index.
REQ-021 W: the last-beat handshake SHALL return the FSM to IDLE and increment wr_ostd_cnt.
REQ-022 Valid and payload SHALL stay stable until the handshake (no valid drop, no payload change).
REQ-023 out_awsize/out_arsize = log2(AXI_DATA_W/8); out_awburst/out_arburst = 2'b01 (INCR).
REQ-024 out_bready SHALL be 1 whenever wr_ostd_cnt!=0.
REQ-025 Each B handshake SHALL decrement wr_ostd_cnt.
REQ-026 in_bresp!=0 on a B handshake SHALL set sticky err_bresp.
REQ-027 out_rready SHALL be 1 whenever rd_ostd_cnt!=0.
REQ-028 Responses are in order with no interleave. The R beat counter SHALL increment per beat and clear on in_rlast.
REQ-029 An R handshake with in_rlast=1 SHALL pop the FIFO and decrement rd_ostd_cnt.
REQ-030 When AW/W completion and B handshake occur in the same cycle, wr_ostd_cnt SHALL be unchanged. Likewise, AR and final-R in the same cycle SHALL leave rd_ostd_cnt unchanged.
REQ-031 B or R handshakes while the counter is 0 SHALL be ignored (no underflow).
REQ-032 idle SHALL be 1 iff state==IDLE and both counts are 0.
REQ-033 Latency: cmd accept -> out_arvalid/out_awvalid is 1 cycle. AW handshake -> first out_wvalid is 1 cycle.

Reset
REQ-034 srst sampled high SHALL force: state IDLE; all out_*valid 0; cmd_ready 0; out_bready 0; out_rready 0; out_wlast 0.
REQ-035 srst SHALL also force: counts 0; FIFO pointers 0; err_bresp 0; err_rlast 0; all payload outputs 0; idle 1.
REQ-036 srst asserted mid-burst SHALL abandon the burst with no further valid in the next cycle.

Configuration
REQ-037 With macro MST_RLAST_CHK_EN defined, a read error SHALL set sticky err_rlast: in_rlast mismatching (beat counter==FIFO head len), or in_rid!=the stored ID. An ID FIFO is added for this check.
REQ-038 Without MST_RLAST_CHK_EN, err_rlast SHALL be tied 0, no ID FIFO SHALL exist, and in_rlast alone SHALL terminate the burst.

Verification
REQ-039 Read: cmd_write=0, addr=0x100, len=3, id=2, arready=1, 4 R beats with rlast on the 4th -> araddr=0x100, arlen=3; rd_ostd_cnt 1->0; err_rlast=0.
REQ-040 Write: addr=0x40, len=1, awready=wready=1 -> wdata 0x40,0x41; wlast on 2nd beat; B resp 0 -> wr_ostd_cnt 1->0; err_bresp=0.
REQ-041 Full: 4 reads with arready=1 and rvalid=0 -> rd_ostd_cnt=4; cmd_ready=0 for a 5th read; cmd_ready=1 for a write.
REQ-042 Backpressure: wready toggling 1/0 on len=3 -> wdata/wlast held while wready=0; exactly 4 W handshakes.
REQ-043 Error: B with bresp=2'b10 -> err_bresp=1, held until srst.
REQ-044 With MST_RLAST_CHK_EN: len=1 read, rlast on beat 1 -> err_rlast=1. Without the macro -> err_rlast stays 0.
